// File: rtl/e203_tcm_mp_ctrl.sv
// N-port TCM controller: arbitrates ICB requestors onto one single-port SRAM,
// with an in-flight stage and an in-order response FIFO (bypassed when empty).
module e203_tcm_mp_ctrl #(
    parameter int unsigned N_PORTS     = 2,
    parameter int unsigned AW          = 16,
    parameter int unsigned DW          = 32,
    parameter int unsigned RAM_AW      = 14,
    parameter int unsigned RAM_DEPTH   = 16384,
    parameter int unsigned ARBT_SCHEME = 0,
    parameter int unsigned OUTS_NUM    = 2,
    localparam int unsigned MW         = DW / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_PORTS-1:0]    i_icb_cmd_valid,
    output logic [N_PORTS-1:0]    i_icb_cmd_ready,
    input  logic [N_PORTS*AW-1:0] i_icb_cmd_addr,
    input  logic [N_PORTS-1:0]    i_icb_cmd_read,
    input  logic [N_PORTS*DW-1:0] i_icb_cmd_wdata,
    input  logic [N_PORTS*MW-1:0] i_icb_cmd_wmask,
    output logic [N_PORTS-1:0]    i_icb_rsp_valid,
    input  logic [N_PORTS-1:0]    i_icb_rsp_ready,
    output logic [N_PORTS-1:0]    i_icb_rsp_err,
    output logic [N_PORTS*DW-1:0] i_icb_rsp_rdata,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic [RAM_AW-1:0]     ram_addr,
    output logic [MW-1:0]         ram_wem,
    output logic [DW-1:0]         ram_din,
    input  logic [DW-1:0]         ram_dout,
    output logic                  tcm_active
);

    localparam int unsigned LMW  = $clog2(MW);
    localparam int unsigned PW   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int unsigned CW   = $clog2(OUTS_NUM + 1);
    localparam int unsigned PTRW = (OUTS_NUM > 1) ? $clog2(OUTS_NUM) : 1;

    typedef struct packed {
        logic [PW-1:0] port;
        logic          err;
        logic [DW-1:0] data;
    } rsp_t;

    logic [PW-1:0]   rr_q, rr_d, win;
    logic            any_vld, can_accept, hsk, in_range;
    logic [N_PORTS-1:0] grant;
    logic [AW-1:0]   sel_addr;
    logic            sel_read;
    logic [DW-1:0]   sel_wdata;
    logic [MW-1:0]   sel_wmask;
    logic [RAM_AW-1:0] word;

    logic            ifl_vld_q, ifl_err_q, ifl_read_q;
    logic [PW-1:0]   ifl_port_q;
    rsp_t            ifl_rsp, head;

    rsp_t            fifo_q [OUTS_NUM];
    logic [PTRW-1:0] rd_q, wr_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            head_vld, pop, push, fifo_pop, fifo_empty;

    assign fifo_empty = (cnt_q == '0);
    assign can_accept = ({1'b0, cnt_q} + (CW+1)'(ifl_vld_q)) < (CW+1)'(OUTS_NUM);
    assign any_vld    = |i_icb_cmd_valid;
    assign hsk        = any_vld & can_accept;

    // Loops run high-to-low so the first candidate in search order wins.
    always_comb begin
        win   = '0;
        grant = '0;
        if (ARBT_SCHEME == 0) begin
            for (int i = N_PORTS - 1; i >= 0; i--) begin
                if (i_icb_cmd_valid[i]) win = PW'(i);
            end
        end else begin
            for (int i = N_PORTS - 1; i >= 0; i--) begin
                if (i_icb_cmd_valid[(int'(rr_q) + i) % N_PORTS]) begin
                    win = PW'((int'(rr_q) + i) % N_PORTS);
                end
            end
        end
        if (any_vld) grant[win] = 1'b1;
    end

    always_comb begin
        sel_addr  = '0;
        sel_read  = 1'b0;
        sel_wdata = '0;
        sel_wmask = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (win == PW'(i)) begin
                sel_addr  = i_icb_cmd_addr[i*AW +: AW];
                sel_read  = i_icb_cmd_read[i];
                sel_wdata = i_icb_cmd_wdata[i*DW +: DW];
                sel_wmask = i_icb_cmd_wmask[i*MW +: MW];
            end
        end
    end

    assign i_icb_cmd_ready = can_accept ? grant : '0;
    assign word            = sel_addr[AW-1:LMW];
    assign in_range        = 32'(word) < RAM_DEPTH;
    assign ram_cs          = hsk & in_range;
    assign ram_we          = ram_cs & ~sel_read;
    assign ram_addr        = hsk ? word : '0;
    assign ram_wem         = ram_we ? sel_wmask : '0;
    assign ram_din         = hsk ? sel_wdata : '0;

    always_comb begin
        rr_d = rr_q;
        if (ARBT_SCHEME != 0 && hsk) begin
            rr_d = (win == PW'(N_PORTS - 1)) ? '0 : win + 1'b1;
        end
    end

    assign ifl_rsp.port = ifl_port_q;
    assign ifl_rsp.err  = ifl_err_q;
    assign ifl_rsp.data = (ifl_read_q & ~ifl_err_q) ? ram_dout : '0;

    assign head_vld = ~fifo_empty | ifl_vld_q;
    assign head     = fifo_empty ? ifl_rsp : fifo_q[rd_q];

    always_comb begin
        i_icb_rsp_valid = '0;
        i_icb_rsp_err   = '0;
        i_icb_rsp_rdata = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            if (head_vld && head.port == PW'(k)) begin
                i_icb_rsp_valid[k]          = 1'b1;
                i_icb_rsp_err[k]            = head.err;
                i_icb_rsp_rdata[k*DW +: DW] = head.data;
            end
        end
    end

    assign pop      = |(i_icb_rsp_valid & i_icb_rsp_ready);
    assign fifo_pop = pop & ~fifo_empty;
    // The in-flight entry is queued unless it left this cycle through the bypass.
    assign push     = ifl_vld_q & ~(fifo_empty & pop);
    assign cnt_d    = cnt_q + CW'(push) - CW'(fifo_pop);

    assign tcm_active = any_vld | ifl_vld_q | ~fifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q       <= '0;
            ifl_vld_q  <= 1'b0;
            ifl_err_q  <= 1'b0;
            ifl_read_q <= 1'b0;
            ifl_port_q <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            cnt_q      <= '0;
            for (int i = 0; i < OUTS_NUM; i++) fifo_q[i] <= '0;
        end else begin
            rr_q       <= rr_d;
            ifl_vld_q  <= hsk;
            ifl_err_q  <= ~in_range;
            ifl_read_q <= sel_read;
            ifl_port_q <= win;
            cnt_q      <= cnt_d;
            if (push) begin
                fifo_q[wr_q] <= ifl_rsp;
                wr_q         <= (wr_q == PTRW'(OUTS_NUM - 1)) ? '0 : wr_q + 1'b1;
            end
            if (fifo_pop) begin
                rd_q <= (rd_q == PTRW'(OUTS_NUM - 1)) ? '0 : rd_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_e203_tcm_mp_ctrl.sv
// Directed bench: a 2-port fixed-priority instance and a 3-port round-robin instance,
// each with a behavioural SRAM model.
module tb_e203_tcm_mp_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    // Fixed-priority DUT, shrunken RAM so an out-of-range word exists.
    logic [1:0]  a_valid, a_ready, a_read, a_rsp_valid, a_rsp_ready, a_rsp_err;
    logic [31:0] a_addr;
    logic [63:0] a_wdata, a_rdata;
    logic [7:0]  a_wmask;
    logic        a_cs, a_we, a_active;
    logic [13:0] a_ram_addr;
    logic [3:0]  a_wem;
    logic [31:0] a_din, a_dout;
    logic [31:0] mem_a [16384];

    e203_tcm_mp_ctrl #(
        .N_PORTS(2), .AW(16), .DW(32), .RAM_AW(14), .RAM_DEPTH(1024),
        .ARBT_SCHEME(0), .OUTS_NUM(2)
    ) u_fp (
        .clk(clk), .rst(rst),
        .i_icb_cmd_valid(a_valid), .i_icb_cmd_ready(a_ready), .i_icb_cmd_addr(a_addr),
        .i_icb_cmd_read(a_read), .i_icb_cmd_wdata(a_wdata), .i_icb_cmd_wmask(a_wmask),
        .i_icb_rsp_valid(a_rsp_valid), .i_icb_rsp_ready(a_rsp_ready),
        .i_icb_rsp_err(a_rsp_err), .i_icb_rsp_rdata(a_rdata),
        .ram_cs(a_cs), .ram_we(a_we), .ram_addr(a_ram_addr), .ram_wem(a_wem),
        .ram_din(a_din), .ram_dout(a_dout), .tcm_active(a_active)
    );

    always_ff @(posedge clk) begin
        if (a_cs) begin
            if (a_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (a_wem[b]) mem_a[a_ram_addr][b*8 +: 8] <= a_din[b*8 +: 8];
                end
            end else begin
                a_dout <= mem_a[a_ram_addr];
            end
        end
    end

    // Round-robin DUT.
    logic [2:0]  b_valid, b_ready, b_read, b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [47:0] b_addr;
    logic [95:0] b_wdata, b_rdata;
    logic [11:0] b_wmask;
    logic        b_cs, b_we, b_active;
    logic [13:0] b_ram_addr;
    logic [3:0]  b_wem;
    logic [31:0] b_din, b_dout;

    e203_tcm_mp_ctrl #(
        .N_PORTS(3), .AW(16), .DW(32), .RAM_AW(14), .RAM_DEPTH(16384),
        .ARBT_SCHEME(1), .OUTS_NUM(2)
    ) u_rr (
        .clk(clk), .rst(rst),
        .i_icb_cmd_valid(b_valid), .i_icb_cmd_ready(b_ready), .i_icb_cmd_addr(b_addr),
        .i_icb_cmd_read(b_read), .i_icb_cmd_wdata(b_wdata), .i_icb_cmd_wmask(b_wmask),
        .i_icb_rsp_valid(b_rsp_valid), .i_icb_rsp_ready(b_rsp_ready),
        .i_icb_rsp_err(b_rsp_err), .i_icb_rsp_rdata(b_rdata),
        .ram_cs(b_cs), .ram_we(b_we), .ram_addr(b_ram_addr), .ram_wem(b_wem),
        .ram_din(b_din), .ram_dout(b_dout), .tcm_active(b_active)
    );

    always_ff @(posedge clk) begin
        if (b_cs && !b_we) b_dout <= {18'h0, b_ram_addr};
    end

    task automatic check_eq(input string tag, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // tick lands 1 time unit after a rising edge; mid moves to the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        #4;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        a_valid = '0; a_read = '0; a_addr = '0; a_wdata = '0; a_wmask = '0; a_rsp_ready = '0;
        b_valid = '0; b_read = '0; b_addr = '0; b_wdata = '0; b_wmask = '0; b_rsp_ready = '0;
        #3;
        check_eq("rst_rsp_valid", 96'(a_rsp_valid), 96'h0);
        check_eq("rst_ram_cs", 96'(a_cs), 96'h0);
        check_eq("rst_active", 96'(a_active), 96'h0);
        check_eq("rst_rr_ready", 96'(b_ready), 96'h0);
        tick(); tick();
        rst = 1'b0;
        mid();
        check_eq("idle_active", 96'(a_active), 96'h0);

        // Write 0xDEADBEEF to 0x10, then read it back.
        tick();
        a_rsp_ready = 2'b11;
        a_valid = 2'b01; a_read = 2'b00; a_addr[15:0] = 16'h0010;
        a_wdata[31:0] = 32'hDEADBEEF; a_wmask[3:0] = 4'hF;
        mid();
        check_eq("wr_ready", 96'(a_ready), 96'h1);
        check_eq("wr_cs_we", 96'({a_cs, a_we}), 96'h3);
        check_eq("wr_addr", 96'(a_ram_addr), 96'h4);
        check_eq("wr_wem", 96'(a_wem), 96'hF);
        check_eq("wr_din", 96'(a_din), 96'hDEADBEEF);
        check_eq("wr_active", 96'(a_active), 96'h1);
        tick();
        a_read = 2'b01;
        mid();
        check_eq("wr_rsp_valid", 96'(a_rsp_valid), 96'h1);
        check_eq("wr_rsp_err", 96'(a_rsp_err), 96'h0);
        check_eq("rd_cs_we", 96'({a_cs, a_we}), 96'h2);
        tick();
        a_valid = 2'b00;
        mid();
        check_eq("rd_rsp_valid", 96'(a_rsp_valid), 96'h1);
        check_eq("rd_rdata", 96'(a_rdata), 96'h0_DEADBEEF);
        check_eq("rd_rsp_err", 96'(a_rsp_err), 96'h0);
        tick();
        mid();
        check_eq("rd_drained", 96'(a_rsp_valid), 96'h0);

        // Fixed priority: port 0 holds the grant while it keeps valid high.
        tick();
        a_valid = 2'b11; a_read = 2'b11; a_addr = {16'h0004, 16'h0000};
        for (int i = 0; i < 3; i++) begin
            mid();
            check_eq($sformatf("fp_p0_%0d", i), 96'(a_ready), 96'h1);
            tick();
        end
        a_valid = 2'b10;
        mid();
        check_eq("fp_p1", 96'(a_ready), 96'h2);
        tick();
        a_valid = 2'b00;
        tick(); tick();

        // Three back-to-back reads with responses stalled.
        a_rsp_ready = 2'b00;
        a_valid = 2'b01; a_read = 2'b01; a_addr[15:0] = 16'h0010;
        mid();
        check_eq("os_hs1", 96'(a_ready), 96'h1);
        tick();
        mid();
        check_eq("os_hs2", 96'(a_ready), 96'h1);
        check_eq("os_stall_valid", 96'(a_rsp_valid), 96'h1);
        tick();
        mid();
        check_eq("os_full1", 96'(a_ready), 96'h0);
        check_eq("os_head_data", 96'(a_rdata), 96'h0_DEADBEEF);
        tick();
        mid();
        check_eq("os_full2", 96'(a_ready), 96'h0);
        tick();
        a_rsp_ready = 2'b01;
        mid();
        check_eq("os_pop_same_cycle", 96'(a_ready), 96'h0);
        check_eq("os_rsp1", 96'(a_rsp_valid), 96'h1);
        tick();
        mid();
        check_eq("os_hs3", 96'(a_ready), 96'h1);
        check_eq("os_rsp2", 96'(a_rsp_valid), 96'h1);
        tick();
        a_valid = 2'b00;
        mid();
        check_eq("os_rsp3", 96'(a_rsp_valid), 96'h1);
        check_eq("os_rsp3_data", 96'(a_rdata), 96'h0_DEADBEEF);
        tick();
        mid();
        check_eq("os_drained", 96'(a_active), 96'h0);

        // Out-of-range read on port 1 (word index 1024).
        tick();
        a_rsp_ready = 2'b11;
        a_valid = 2'b10; a_read = 2'b10; a_addr[31:16] = 16'h1000;
        mid();
        check_eq("oor_ready", 96'(a_ready), 96'h2);
        check_eq("oor_cs", 96'(a_cs), 96'h0);
        tick();
        a_valid = 2'b00;
        mid();
        check_eq("oor_valid", 96'(a_rsp_valid), 96'h2);
        check_eq("oor_err", 96'(a_rsp_err), 96'h2);
        check_eq("oor_rdata", 96'(a_rdata), 96'h0);
        tick();

        // Reset with two reads outstanding.
        a_rsp_ready = 2'b00;
        a_valid = 2'b01; a_read = 2'b01; a_addr[15:0] = 16'h0010;
        tick();
        tick();
        a_valid = 2'b00;
        mid();
        check_eq("mid_pre_valid", 96'(a_rsp_valid), 96'h1);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_valid", 96'(a_rsp_valid), 96'h0);
        tick();
        rst = 1'b0;
        mid();
        check_eq("post_rst_valid", 96'(a_rsp_valid), 96'h0);
        check_eq("post_rst_active", 96'(a_active), 96'h0);
        tick();
        mid();
        check_eq("post_rst_valid2", 96'(a_rsp_valid), 96'h0);

        // Round robin over three always-valid ports.
        tick();
        b_rsp_ready = 3'b111;
        b_valid = 3'b111; b_read = 3'b111; b_addr = {16'h0008, 16'h0004, 16'h0000};
        for (int i = 0; i < 6; i++) begin
            logic [2:0] exp_g;
            exp_g = 3'b001 << (i % 3);
            mid();
            check_eq($sformatf("rr_grant_%0d", i), 96'(b_ready), 96'(exp_g));
            tick();
        end
        b_rsp_ready = 3'b000;
        mid();
        check_eq("rr_grant_6", 96'(b_ready), 96'h1);
        tick();
        mid();
        check_eq("rr_full1", 96'(b_ready), 96'h0);
        tick();
        mid();
        check_eq("rr_full2", 96'(b_ready), 96'h0);
        check_eq("rr_head_port2", 96'(b_rsp_valid), 96'h4);
        check_eq("rr_head_data", 96'(b_rdata), {32'h2, 64'h0});
        tick();
        b_rsp_ready = 3'b111;
        mid();
        check_eq("rr_pop_cycle", 96'(b_ready), 96'h0);
        tick();
        mid();
        check_eq("rr_ptr_held", 96'(b_ready), 96'h2);
        tick();
        b_valid = 3'b000;
        tick(); tick(); tick();
        mid();
        check_eq("rr_drained", 96'(b_active), 96'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/e203_tcm_mp_ctrl.md
Name: e203_tcm_mp_ctrl

Overview:
- Parametrised N-port TCM controller, successor to the single/dual-requestor DTCM controller.
- Arbitrates N ICB requestors (LSU, external agents, DMA, debug) onto one single-port synchronous SRAM.
- Selectable fixed-priority or round-robin arbitration; multiple outstanding transactions with an in-order response queue.
- Out-of-range addresses get an error response and never touch the RAM.
- Sits between the core/bus fabric and the TCM SRAM macro, in the same place as the DTCM controller.

Parameters:
- N_PORTS, 2, number of ICB requestor ports (1..8).
- AW, 16, ICB byte-address width.
- DW, 32, data width (32 or 64); MW = DW/8 is the byte-mask width.
- RAM_AW, 14, SRAM word-address width, equal to AW - log2(MW).
- RAM_DEPTH, 16384, number of implemented words; word index >= RAM_DEPTH is out of range.
- ARBT_SCHEME, 0, 0 = fixed priority (port 0 highest), 1 = round robin.
- OUTS_NUM, 2, maximum outstanding transactions (1..4); also the response FIFO depth.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- i_icb_cmd_valid  in  N_PORTS  per-port command valid.
- i_icb_cmd_ready  out  N_PORTS  per-port command ready.
- i_icb_cmd_addr  in  N_PORTS*AW  byte addresses, port k at [k*AW +: AW].
- i_icb_cmd_read  in  N_PORTS  1 = read, 0 = write.
- i_icb_cmd_wdata  in  N_PORTS*DW  write data.
- i_icb_cmd_wmask  in  N_PORTS*MW  byte write enables.
- i_icb_rsp_valid  out  N_PORTS  per-port response valid.
- i_icb_rsp_ready  in  N_PORTS  per-port response ready.
- i_icb_rsp_err  out  N_PORTS  response error.
- i_icb_rsp_rdata  out  N_PORTS*DW  read data.
- ram_cs  out  1  SRAM chip select.
- ram_we  out  1  SRAM write enable.
- ram_addr  out  RAM_AW  word address.
- ram_wem  out  MW  byte write mask.
- ram_din  out  DW  SRAM write data.
- ram_dout  in  DW  SRAM read data, valid the cycle after a cs+read.
- tcm_active  out  1  OR of any cmd_valid, any in-flight transaction, and any FIFO entry; used for clock gating upstream.

Behaviour:
Reset:
- All outputs reset to 0 (tcm_active = 0 with cmd_valid inputs low).
- FIFO empty, in-flight flag clear, RR pointer = 0.
- Reset mid-operation drops all outstanding transactions; no response is issued for them.

Occupancy and command acceptance:
- occ = FIFO count + in-flight flag.
- can_accept = (occ < OUTS_NUM); there is no pass-through when full.

Arbitration:
- Fixed priority: the lowest-index valid port wins.
- Round robin: search starts at the RR pointer. On handshake the pointer moves to (winner+1) mod N_PORTS and wraps. Without a handshake the pointer holds.
- i_icb_cmd_ready[k] = can_accept & grant[k]; non-winners see ready = 0.
- Grant is combinational and has no lock. A requester may drop valid before handshake.

Command stage (cycle T, handshake):
- In-range: ram_cs = 1, ram_we = ~read, ram_addr = addr[AW-1:log2(MW)], ram_wem = read ? 0 : wmask, ram_din = wdata.
- Out-of-range: ram_cs = 0.
- In both cases an in-flight record {port id, err, is_read} is registered.
- ram_cs is never asserted without a handshake.

Response stage (T+1):
- The in-flight record plus data form the response. Data = ram_dout for in-range reads, 0 for writes and errors.
- If the FIFO is empty, the response is driven directly: 1-cycle latency, bypass path.
- Otherwise, or if not accepted this cycle, it is pushed into the FIFO.
- When an error and a stall coincide, the in-flight data is still captured into the FIFO, so no data is lost.

Output:
- Only the FIFO head (or bypass entry) is presented.
- i_icb_rsp_valid[head.port] = 1; every other port's rsp_valid = 0.
- rsp_err and rsp_rdata are routed to that port only; other ports see 0.
- Responses are strictly in command order. A stalled head blocks all ports (head-of-line blocking by design).
- Pop on rsp_valid & rsp_ready.

Throughput and simultaneity:
- One command per cycle sustained when OUTS_NUM >= 2 and rsp_ready is held high.
- Push and pop in the same cycle leave the count unchanged.
- When full, a pop frees a slot the next cycle, not the same cycle.

Test Plan:
- Single port, write 0xDEADBEEF at addr 0x10 with wmask 0xF, then read 0x10 -> ram_we pulse with ram_addr = 4; the read rsp arrives 1 cycle after handshake with rdata = 0xDEADBEEF and err = 0.
- ARBT_SCHEME = 0, ports 0 and 1 both valid continuously -> port 0 granted every cycle; port 1 is granted only once port 0 drops valid.
- ARBT_SCHEME = 1, N_PORTS = 3, all valid -> grant sequence 0, 1, 2, 0, 1, 2; the pointer holds while can_accept = 0.
- OUTS_NUM = 2, rsp_ready held 0, 3 reads issued back to back -> 2 handshakes, then cmd_ready = 0. Release rsp_ready -> responses come back in order, and the third command is accepted the cycle after the first pop.
- Read at word index RAM_DEPTH -> ram_cs stays 0; rsp err = 1 and rdata = 0 on the issuing port only.
- Assert rst with 2 transactions outstanding -> all rsp_valid = 0 immediately. After reset release, no stale response appears and tcm_active = 0.
